// File: rtl/wav_frame_sequencer.sv
// rtl/wav_frame_sequencer.sv - packs host samples into frames for the audio core and drains results
module wav_frame_sequencer #(
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          load_size,
  input  logic                      in_valid,
  input  logic [SAMPLE_W-1:0]       in_sample,
  output logic                      in_ready,
  output logic                      buffer_load,
  output logic [LANES*SAMPLE_W-1:0] frame_out,
  input  logic                      core_output_load,
  input  logic [LANES*SAMPLE_W-1:0] core_data,
  output logic                      out_valid,
  output logic [SAMPLE_W-1:0]       out_sample,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      wav_done,
  output logic                      err
);

  // lane_idx/frame_cnt must reach LANES, so they need one more value than a lane select
  localparam int IDX_W = $clog2(LANES + 1);
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    WAIT_CORE,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SAMPLE_W-1:0] frame_q  [LANES];
  logic [SAMPLE_W-1:0] result_q [LANES];
  logic [CNT_W-1:0]    remaining_q;
  logic [IDX_W-1:0]    lane_idx_q;
  logic [IDX_W-1:0]    drain_idx_q;
  logic [IDX_W-1:0]    frame_cnt_q;
  logic [WD_W-1:0]     wd_q;
  logic                err_q;

  logic             in_fire;
  logic             out_fire;
  logic             frame_full;
  logic             last_drain;
  logic             wd_expire;
  logic [SEL_W-1:0] lane_sel;
  logic [SEL_W-1:0] drain_sel;

  assign lane_sel   = lane_idx_q[SEL_W-1:0];
  assign drain_sel  = drain_idx_q[SEL_W-1:0];
  assign in_fire    = in_ready && in_valid;
  assign out_fire   = out_valid && out_ready;
  // the sample being accepted either fills the last lane or is the last one in the file
  assign frame_full = (lane_idx_q == IDX_W'(LANES - 1)) || (remaining_q == CNT_W'(1));
  assign last_drain = (drain_idx_q == frame_cnt_q - IDX_W'(1));
  // wd_q holds the number of WAIT_CORE cycles including the current one
  assign wd_expire  = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT));

  // state-decoded outputs; in_ready depends on state only
  assign in_ready    = (state_q == FILL);
  assign buffer_load = (state_q == LOAD);
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign wav_done    = (state_q == DONE);
  assign err         = err_q;

  // flatten the frame lanes and select the current result lane
  always_comb begin
    frame_out  = '0;
    out_sample = '0;
    for (int k = 0; k < LANES; k++) begin
      frame_out[k*SAMPLE_W +: SAMPLE_W] = frame_q[k];
    end
    if (out_valid) begin
      out_sample = result_q[drain_sel];
    end
  end

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; a core capture takes priority over watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (load_size == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (in_fire && frame_full) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_output_load) begin
          state_d = DRAIN;
        end else if (wd_expire) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (out_fire && last_drain) begin
          state_d = (remaining_q == '0) ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // datapath: frame packing, sample counting, watchdog, result capture and drain index
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < LANES; k++) begin
        frame_q[k]  <= '0;
        result_q[k] <= '0;
      end
      remaining_q <= '0;
      lane_idx_q  <= '0;
      drain_idx_q <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= load_size;
            err_q       <= 1'b0;
            lane_idx_q  <= '0;
            frame_cnt_q <= '0;
            for (int k = 0; k < LANES; k++) begin
              frame_q[k] <= '0;
            end
          end
        end
        FILL: begin
          if (in_fire && (remaining_q != '0)) begin
            frame_q[lane_sel] <= in_sample;
            lane_idx_q        <= lane_idx_q + IDX_W'(1);
            frame_cnt_q       <= lane_idx_q + IDX_W'(1);
            remaining_q       <= remaining_q - CNT_W'(1);
          end
        end
        LOAD: begin
          wd_q <= WD_W'(1);
        end
        WAIT_CORE: begin
          if (core_output_load) begin
            for (int k = 0; k < LANES; k++) begin
              result_q[k] <= core_data[k*SAMPLE_W +: SAMPLE_W];
            end
            drain_idx_q <= '0;
          end else if (wd_expire) begin
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (last_drain) begin
              if (remaining_q != '0) begin
                lane_idx_q <= '0;
                for (int k = 0; k < LANES; k++) begin
                  frame_q[k] <= '0;
                end
              end
            end else begin
              drain_idx_q <= drain_idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wav_frame_sequencer.sv
// tb/tb_wav_frame_sequencer.sv - directed table-driven bench for wav_frame_sequencer
module tb_wav_frame_sequencer;

  localparam int LANES    = 8;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 32;
  localparam int TIMEOUT  = 16;

  logic                      clk = 1'b0;
  logic                      n_rst = 1'b0;
  logic                      start = 1'b0;
  logic [CNT_W-1:0]          load_size = '0;
  logic                      in_valid = 1'b0;
  logic [SAMPLE_W-1:0]       in_sample = '0;
  logic                      in_ready;
  logic                      buffer_load;
  logic [LANES*SAMPLE_W-1:0] frame_out;
  logic                      core_output_load;
  logic [LANES*SAMPLE_W-1:0] core_data;
  logic                      out_valid;
  logic [SAMPLE_W-1:0]       out_sample;
  logic                      out_ready;
  logic                      busy;
  logic                      wav_done;
  logic                      err;

  wav_frame_sequencer #(
    .LANES(LANES), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .load_size(load_size),
    .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .buffer_load(buffer_load), .frame_out(frame_out),
    .core_output_load(core_output_load), .core_data(core_data),
    .out_valid(out_valid), .out_sample(out_sample), .out_ready(out_ready),
    .busy(busy), .wav_done(wav_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] sample_of(input int mode, input int i);
    logic [15:0] v;
    if (mode == 1) begin
      v = 16'(i + 1);
    end else begin
      case (i % 8)
        0: v = 16'd112;
        1: v = 16'd256;
        2: v = 16'd300;
        3: v = 16'd4000;
        4: v = 16'd3567;
        5: v = 16'd356;
        6: v = 16'd287;
        default: v = 16'd119;
      endcase
    end
    return v;
  endfunction

  // core model and host output-side stimulus
  int          core_en    = 1;
  int          core_delay = 2;
  logic [15:0] core_xor   = '0;
  int          out_mode   = 0;

  initial begin
    core_output_load = 1'b0;
    core_data        = '0;
    forever begin
      @(negedge clk);
      if (buffer_load && core_en != 0 && n_rst) begin
        for (int k = 0; k < LANES; k++)
          core_data[k*SAMPLE_W +: SAMPLE_W] = frame_out[k*SAMPLE_W +: SAMPLE_W] ^ core_xor;
        repeat (core_delay) @(negedge clk);
        core_output_load = 1'b1;
        @(negedge clk);
        core_output_load = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = (out_mode == 0) ? 1'b1 : ((cyc % 3) != 1);
    end
  end

  // monitor samples shortly before the rising edge
  logic [15:0]  out_q[$];
  int           out_edge_q[$];
  int           bl_cyc_q[$];
  logic [127:0] bl_frame_q[$];
  int           done_cyc_q[$];
  logic         done_err_q[$];
  logic         done_busy_q[$];
  int           acc_edge_q[$];
  int           in_ready_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [15:0]  prev_sample = '0;

  always @(negedge clk) begin
    #3;
    if (n_rst) begin
      if (prev_stall) check("out_hold", {out_valid, out_sample}, {1'b1, prev_sample});
      if (buffer_load || out_valid) check("in_ready_low", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        out_q.push_back(out_sample);
        out_edge_q.push_back(cyc + 1);
      end
      if (buffer_load) begin
        bl_cyc_q.push_back(cyc);
        bl_frame_q.push_back(frame_out);
      end
      if (wav_done) begin
        done_cyc_q.push_back(cyc);
        done_err_q.push_back(err);
        done_busy_q.push_back(busy);
      end
      if (in_ready) in_ready_cnt <= in_ready_cnt + 1;
      prev_stall  <= out_valid && !out_ready;
      prev_sample <= out_sample;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic send(input int n, input int mode, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_sample = sample_of(mode, i);
      guard = 0;
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        check("send_timeout", i, n);
        in_valid = 1'b0;
        return;
      end
      acc_edge_q.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int base);
    int guard = 0;
    while (done_cyc_q.size() == base && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) check("done_timeout", guard, 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          size;
    int          mode;
    int          gap;
    int          omode;
    logic [15:0] xr;
    int          frames;
    int          outs;
  } vec_t;

  vec_t vecs[7];

  task automatic run_file(input vec_t v);
    int b_out, b_bl, b_done, b_acc, b_ir, start_edge, bad, last, nlast;
    logic [127:0] exp_frame;
    b_out = out_q.size(); b_bl = bl_cyc_q.size(); b_done = done_cyc_q.size();
    b_acc = acc_edge_q.size(); b_ir = in_ready_cnt;
    core_xor = v.xr; out_mode = v.omode;
    load_size = v.size; start = 1'b1; start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0; load_size = '0;
    send(v.size, v.mode, v.gap);
    wait_done(b_done);
    check("done_count", done_cyc_q.size() - b_done, 1);
    check("frame_count", bl_cyc_q.size() - b_bl, v.frames);
    check("out_count", out_q.size() - b_out, v.outs);
    if (out_q.size() - b_out == v.outs) begin
      bad = 0;
      for (int i = 0; i < v.outs; i++)
        if (out_q[b_out + i] !== (sample_of(v.mode, i) ^ v.xr)) bad++;
      check("out_data", bad, 0);
    end
    if (bl_cyc_q.size() - b_bl == v.frames && acc_edge_q.size() - b_acc == v.size && v.frames > 0) begin
      bad = 0;
      for (int f = 0; f < v.frames; f++) begin
        last = ((f + 1) * 8 < v.size) ? (f + 1) * 8 - 1 : v.size - 1;
        if (bl_cyc_q[b_bl + f] != acc_edge_q[b_acc + last]) bad++;
      end
      check("load_latency", bad, 0);
      nlast = v.size - (v.frames - 1) * 8;
      exp_frame = '0;
      for (int k = 0; k < nlast; k++)
        exp_frame[k*16 +: 16] = sample_of(v.mode, (v.frames - 1) * 8 + k);
      check("last_frame_pad", bl_frame_q[b_bl + v.frames - 1], exp_frame);
    end
    if (done_cyc_q.size() - b_done == 1) begin
      if (v.outs > 0 && out_edge_q.size() - b_out == v.outs)
        check("done_timing", done_cyc_q[b_done], out_edge_q[b_out + v.outs - 1]);
      else if (v.size == 0)
        check("done_timing", done_cyc_q[b_done], start_edge);
      check("done_flags", {done_err_q[b_done], done_busy_q[b_done]}, 2'b01);
    end
    if (v.gap == 0) check("in_ready_cycles", in_ready_cnt - b_ir, v.size);
    check("idle_after", {busy, in_ready, out_valid}, 3'b000);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_done, b_bl, b_out, bad, guard;

    //        size mode gap omode xor       frames outs
    vecs[0] = '{16, 0, 0, 0, 16'h0000, 2, 16};
    vecs[1] = '{5,  1, 0, 0, 16'h5A5A, 1, 5};
    vecs[2] = '{0,  1, 0, 0, 16'h0000, 0, 0};
    vecs[3] = '{8,  1, 2, 1, 16'h00FF, 1, 8};
    vecs[4] = '{9,  0, 1, 1, 16'h1234, 2, 9};
    vecs[5] = '{1,  1, 0, 0, 16'hFFFF, 1, 1};
    vecs[6] = '{8,  1, 0, 0, 16'h0F0F, 1, 8};

    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {in_ready, buffer_load, out_valid, out_sample, busy, wav_done, err}, '0);
    check("reset_frame", frame_out, '0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_ctrl", {in_ready, buffer_load, out_valid, busy, wav_done, err}, '0);

    for (int r = 0; r < 6; r++) run_file(vecs[r]);

    // core answers in the very cycle the watchdog expires: capture must win
    core_delay = TIMEOUT;
    run_file(vecs[6]);
    core_delay = 2;

    // core never answers: watchdog error and wav_done TIMEOUT cycles after entering WAIT_CORE
    core_en = 0;
    b_done = done_cyc_q.size(); b_bl = bl_cyc_q.size(); b_out = out_q.size();
    load_size = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8, 1, 0);
    wait_done(b_done);
    if (done_cyc_q.size() > b_done && bl_cyc_q.size() > b_bl) begin
      check("wd_delay", done_cyc_q[b_done] - bl_cyc_q[b_bl], TIMEOUT + 1);
      check("wd_flags", {done_err_q[b_done], done_busy_q[b_done]}, 2'b11);
    end else begin
      check("wd_seen", done_cyc_q.size() - b_done, 1);
    end
    check("wd_no_out", out_q.size() - b_out, 0);
    check("err_sticky", {err, busy}, 2'b10);
    core_en = 1;
    run_file(vecs[2]);
    check("err_cleared", err, 1'b0);

    // reset during the drain of the second frame
    b_done = done_cyc_q.size(); b_out = out_q.size();
    out_mode = 0; core_xor = '0;
    load_size = 16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(16, 0, 0);
    guard = 0;
    while (out_q.size() - b_out < 10 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("in_drain", out_valid, 1'b1);
    n_rst = 1'b0;
    #1;
    check("rst_ctrl", {in_ready, buffer_load, out_valid, out_sample, busy, wav_done, err}, '0);
    check("rst_frame", frame_out, '0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cyc_q.size() - b_done, 0);

    // fresh run with a start pulse while busy that must be ignored
    b_done = done_cyc_q.size(); b_out = out_q.size(); b_bl = bl_cyc_q.size();
    core_xor = 16'h00AA;
    load_size = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_size = '0;
    fork
      send(8, 1, 1);
      begin
        repeat (4) @(negedge clk);
        load_size = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; load_size = '0;
      end
    join
    wait_done(b_done);
    check("fresh_done", done_cyc_q.size() - b_done, 1);
    check("fresh_frames", bl_cyc_q.size() - b_bl, 1);
    check("fresh_outs", out_q.size() - b_out, 8);
    if (out_q.size() - b_out == 8) begin
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (out_q[b_out + i] !== (sample_of(1, i) ^ 16'h00AA)) bad++;
      check("fresh_data", bad, 0);
    end
    check("fresh_idle", {busy, err}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
